// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, PC step, fetch FSM encoding and address type.
// No ports; imported by the fetch stage and its target generator.
// Pure declarations, no logic.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [63:0] PC_STEP = 64'd4;

    // Explicit 2-bit base so the encoding is stable across tools.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef logic [63:0] addr_t;

endpackage

// File: rtl/pc_target.sv
// Redirect target generator: register target or br_pc + (word offset << 2).
// Ports: br_reg/br_pc/br_offset/br_reg_target in; target_o, misalign_o out.
// Purely combinational, zero latency, no handshake.
module pc_target #(
    parameter int ADDR_W = 64
) (
    input  logic              br_reg,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [63:0]       br_offset,
    input  logic [ADDR_W-1:0] br_reg_target,
    output logic [ADDR_W-1:0] target_o,
    output logic              misalign_o
);
    import cpu_pkg::*;

    logic [63:0] off_bytes;

    // Word offset to byte offset; bits shifted out the top are dropped so the
    // sum wraps modulo 2^ADDR_W.
    assign off_bytes  = br_offset << 2;
    assign target_o   = br_reg ? br_reg_target : (br_pc + off_bytes[ADDR_W-1:0]);
    assign misalign_o = (target_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: PC register, imem address, IF/ID slot with valid/ready to decode.
// Ports: clk/reset, imem_addr/imem_instr, if_valid/if_instr/if_pc/id_ready,
//        br_* redirect, halt_req/halted, sticky misalign_err. Fetch latency 1 cycle.
module pc_fetch
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          ADDR_W   = 64
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready,
    input  logic               br_taken,
    input  logic               br_reg,
    input  logic [ADDR_W-1:0]  br_pc,
    input  logic [63:0]        br_offset,
    input  logic [ADDR_W-1:0]  br_reg_target,
    input  logic               halt_req,
    output logic               halted,
    output logic               misalign_err
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               vld_q, vld_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
    logic               mis_q, mis_d;

    logic [ADDR_W-1:0]  target;
    logic               target_mis;
    logic               slot_free;

    pc_target #(.ADDR_W(ADDR_W)) u_target (
        .br_reg        (br_reg),
        .br_pc         (br_pc),
        .br_offset     (br_offset),
        .br_reg_target (br_reg_target),
        .target_o      (target),
        .misalign_o    (target_mis)
    );

    // Slot can take a new instruction when empty or being drained this cycle.
    assign slot_free = !vld_q || id_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = vld_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        mis_d   = mis_q;

        if (br_taken) begin
            // Redirect in any state; fetched slot is discarded even if stalled.
            pc_d  = {target[ADDR_W-1:2], 2'b00};
            mis_d = mis_q | target_mis;
            vld_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = RUN;
                RUN: begin
                    if (halt_req) begin
                        // No fetch; a slot accepted this cycle still drains.
                        state_d = HALT;
                        if (vld_q && id_ready) vld_d = 1'b0;
                    end else if (slot_free) begin
                        instr_d = imem_instr;
                        ifpc_d  = pc_q;
                        vld_d   = 1'b1;
                        pc_d    = pc_q + PC_STEP[ADDR_W-1:0];
                    end
                end
                HALT: begin
                    if (vld_q && id_ready) vld_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC[ADDR_W-1:0];
            vld_q   <= 1'b0;
            instr_q <= '0;
            ifpc_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_addr    = pc_q;
    assign if_valid     = vld_q;
    assign if_instr     = instr_q;
    assign if_pc        = ifpc_q;
    assign halted       = (state_q == HALT);
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic        br_taken;
    logic        br_reg;
    logic [63:0] br_pc;
    logic [63:0] br_offset;
    logic [63:0] br_reg_target;
    logic        halt_req;
    logic        halted;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Instruction memory: word content derived from its address.
    assign imem_instr = imem_addr[31:0] ^ 32'hA5A5_0000;

    pc_fetch #(.RESET_PC(64'h100), .ADDR_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .id_ready      (id_ready),
        .br_taken      (br_taken),
        .br_reg        (br_reg),
        .br_pc         (br_pc),
        .br_offset     (br_offset),
        .br_reg_target (br_reg_target),
        .halt_req      (halt_req),
        .halted        (halted),
        .misalign_err  (misalign_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; id_ready = 1'b1; br_taken = 1'b0; br_reg = 1'b0;
        br_pc = '0; br_offset = '0; br_reg_target = '0; halt_req = 1'b0;
        step();
        step();
        total++; if (imem_addr !== 64'h100) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 64'h100); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
        total++; if (if_pc !== 64'h0 || if_instr !== 32'h0) begin bad++; $display("FAIL reset_slot pc=%h instr=%h exp 0", if_pc, if_instr); end
        total++; if (halted !== 1'b0 || misalign_err !== 1'b0) begin bad++; $display("FAIL reset_flags halted=%b mis=%b exp 0", halted, misalign_err); end
        reset = 1'b0;
        step();
        total++; if (if_valid !== 1'b0 || imem_addr !== 64'h100) begin bad++; $display("FAIL idle_cycle valid=%b addr=%h exp 0/100", if_valid, imem_addr); end
        step();
        total++; if (if_valid !== 1'b1 || if_pc !== 64'h100 || if_instr !== 32'hA5A5_0100) begin bad++; $display("FAIL first_fetch valid=%b pc=%h instr=%h exp 1/100/a5a50100", if_valid, if_pc, if_instr); end
        step();
        total++; if (if_pc !== 64'h104 || imem_addr !== 64'h108) begin bad++; $display("FAIL second_fetch pc=%h addr=%h exp 104/108", if_pc, imem_addr); end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (if_valid !== 1'b1 || if_pc !== 64'h104 || if_instr !== 32'hA5A5_0104 || imem_addr !== 64'h108) begin
                bad++; $display("FAIL stall_hold cyc=%0d valid=%b pc=%h instr=%h addr=%h exp 1/104/a5a50104/108", i, if_valid, if_pc, if_instr, imem_addr);
            end
        end
        id_ready = 1'b1;
        step();
        total++; if (if_pc !== 64'h108 || if_instr !== 32'hA5A5_0108 || imem_addr !== 64'h10C) begin bad++; $display("FAIL stall_release pc=%h instr=%h addr=%h exp 108/a5a50108/10c", if_pc, if_instr, imem_addr); end
    endtask

    task automatic test_branch_back();
        br_taken = 1'b1; br_reg = 1'b0; br_pc = 64'h200; br_offset = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        total++; if (imem_addr !== 64'h1F8 || if_valid !== 1'b0) begin bad++; $display("FAIL br_back_redirect addr=%h valid=%b exp 1f8/0", imem_addr, if_valid); end
        br_taken = 1'b0;
        step();
        total++; if (if_valid !== 1'b1 || if_pc !== 64'h1F8 || imem_addr !== 64'h1FC || misalign_err !== 1'b0) begin bad++; $display("FAIL br_back_target valid=%b pc=%h addr=%h mis=%b exp 1/1f8/1fc/0", if_valid, if_pc, imem_addr, misalign_err); end
    endtask

    task automatic test_branch_stall();
        id_ready = 1'b0;
        step();
        total++; if (if_valid !== 1'b1 || if_pc !== 64'h1F8) begin bad++; $display("FAIL brst_stall valid=%b pc=%h exp 1/1f8", if_valid, if_pc); end
        br_taken = 1'b1; br_reg = 1'b1; br_reg_target = 64'h3002;
        step();
        total++; if (if_valid !== 1'b0 || imem_addr !== 64'h3000 || misalign_err !== 1'b1) begin bad++; $display("FAIL brst_flush valid=%b addr=%h mis=%b exp 0/3000/1", if_valid, imem_addr, misalign_err); end
        br_taken = 1'b0; br_reg = 1'b0; id_ready = 1'b1;
        step();
        total++; if (if_valid !== 1'b1 || if_pc !== 64'h3000 || if_instr !== 32'hA5A5_3000) begin bad++; $display("FAIL brst_target valid=%b pc=%h instr=%h exp 1/3000/a5a53000", if_valid, if_pc, if_instr); end
        step();
        total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL brst_sticky mis=%b exp 1", misalign_err); end
    endtask

    task automatic test_wrap();
        br_taken = 1'b1; br_reg = 1'b1; br_reg_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        br_taken = 1'b0; br_reg = 1'b0;
        total++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_load addr=%h exp fffffffffffffffc", imem_addr); end
        step();
        total++; if (if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_instr !== 32'h5A5A_FFFC || imem_addr !== 64'h0) begin bad++; $display("FAIL wrap_advance pc=%h instr=%h addr=%h exp fffffffffffffffc/5a5afffc/0", if_pc, if_instr, imem_addr); end
        step();
        total++; if (if_pc !== 64'h0 || imem_addr !== 64'h4) begin bad++; $display("FAIL wrap_after pc=%h addr=%h exp 0/4", if_pc, imem_addr); end
        br_taken = 1'b1; br_pc = 64'hFFFF_FFFF_FFFF_FFF0; br_offset = 64'd8;
        step();
        br_taken = 1'b0;
        total++; if (imem_addr !== 64'h10 || if_valid !== 1'b0) begin bad++; $display("FAIL wrap_branch addr=%h valid=%b exp 10/0", imem_addr, if_valid); end
    endtask

    task automatic test_halt();
        step();
        total++; if (if_valid !== 1'b1 || if_pc !== 64'h10 || imem_addr !== 64'h14) begin bad++; $display("FAIL halt_pre valid=%b pc=%h addr=%h exp 1/10/14", if_valid, if_pc, imem_addr); end
        id_ready = 1'b0; halt_req = 1'b1;
        step();
        total++; if (halted !== 1'b1 || if_valid !== 1'b1 || if_pc !== 64'h10 || imem_addr !== 64'h14) begin bad++; $display("FAIL halt_enter halted=%b valid=%b pc=%h addr=%h exp 1/1/10/14", halted, if_valid, if_pc, imem_addr); end
        halt_req = 1'b0;
        step();
        total++; if (halted !== 1'b1 || if_valid !== 1'b1 || imem_addr !== 64'h14) begin bad++; $display("FAIL halt_keep halted=%b valid=%b addr=%h exp 1/1/14", halted, if_valid, imem_addr); end
        id_ready = 1'b1;
        step();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL halt_drain valid=%b exp 0", if_valid); end
        step();
        total++; if (if_valid !== 1'b0 || imem_addr !== 64'h14 || halted !== 1'b1) begin bad++; $display("FAIL halt_nofetch valid=%b addr=%h halted=%b exp 0/14/1", if_valid, imem_addr, halted); end
        br_taken = 1'b1; br_reg = 1'b1; br_reg_target = 64'h400;
        step();
        br_taken = 1'b0; br_reg = 1'b0;
        total++; if (imem_addr !== 64'h400 || halted !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL halt_branch addr=%h halted=%b valid=%b exp 400/1/0", imem_addr, halted, if_valid); end
        step();
        total++; if (if_valid !== 1'b0 || imem_addr !== 64'h400) begin bad++; $display("FAIL halt_branch_stay valid=%b addr=%h exp 0/400", if_valid, imem_addr); end
        reset = 1'b1;
        step();
        total++; if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 64'h100 || misalign_err !== 1'b0) begin bad++; $display("FAIL halt_reset halted=%b valid=%b addr=%h mis=%b exp 0/0/100/0", halted, if_valid, imem_addr, misalign_err); end
        reset = 1'b0;
        step();
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reidle valid=%b exp 0", if_valid); end
        step();
        total++; if (if_valid !== 1'b1 || if_pc !== 64'h100) begin bad++; $display("FAIL refetch valid=%b pc=%h exp 1/100", if_valid, if_pc); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch_back();
        test_branch_stall();
        test_wrap();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage of the 64-bit pipelined CPU. It holds the program counter, presents it to instruction memory, and registers the returned instruction into the IF/ID pipeline register with a valid/ready handshake toward decode. It consumes the 64-bit sign-extended branch word offset produced by the sign-extension stage. It forms the redirect target `br_pc + (offset << 2)` and flushes the fetched slot on a taken branch.

## Interface
- `RESET_PC`, default `64'h0`: PC loaded on reset.
- `ADDR_W`, default `64`: PC/address width.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_addr` out `ADDR_W`: current PC, combinational from the PC register.
- `imem_instr` in 32: instruction at `imem_addr`, valid in the same cycle (combinational memory).
- `if_valid` out 1: IF/ID slot holds an instruction.
- `if_instr` out 32: registered instruction.
- `if_pc` out `ADDR_W`: PC of `if_instr`.
- `id_ready` in 1: decode accepts the slot this cycle.
- `br_taken` in 1: redirect request from branch resolution.
- `br_reg` in 1: 1 selects register target (BR); 0 selects PC-relative.
- `br_pc` in `ADDR_W`: PC of the branch instruction.
- `br_offset` in 64: sign-extended word offset from the sign extender.
- `br_reg_target` in `ADDR_W`: register-sourced target.
- `halt_req` in 1: stop fetching.
- `halted` out 1: high in HALT state.
- `misalign_err` out 1: sticky flag, a redirect target had bits [1:0] ≠ 0.

## Operation
- Transfer to decode occurs on a cycle with `if_valid && id_ready`. The slot may load when `!if_valid || id_ready`.
- States:
  - IDLE (entered on reset): the slot stays empty for one cycle, then moves to RUN.
  - RUN: normal fetch.
  - HALT: entered from RUN when `halt_req` is high. Left only by `reset`.
- Per-cycle priority is reset > `br_taken` > `halt_req` > stall > advance.
- Reset: `pc = RESET_PC`; `if_valid = 0`, `if_instr = 0`, `if_pc = 0`, `misalign_err = 0`, `halted = 0`; state IDLE.
- `br_taken` in any non-reset state:
  - target = `br_reg ? br_reg_target : br_pc + (br_offset << 2)`, modulo 2^ADDR_W (wrap, no overflow flag).
  - `pc <= {target[ADDR_W-1:2], 2'b00}`. If `target[1:0] != 0`, set `misalign_err`.
  - `if_valid <= 0`: the slot is flushed even when stalled. The state is unchanged.
- RUN advance (slot may load, no branch): `if_instr <= imem_instr`, `if_pc <= pc`, `if_valid <= 1`, `pc <= pc + 4` (wraps at 2^ADDR_W).
- RUN stall (`if_valid && !id_ready`, no branch): PC and slot hold.
- `halt_req` in RUN with no branch: no fetch that cycle. The state becomes HALT and the PC holds.
- HALT:
  - The existing valid slot is kept until accepted, after which `if_valid <= 0`. No new fetch occurs.
  - `br_taken` still updates the PC and flushes the slot, and the state stays HALT.

## Timing
- Fetch latency: an instruction at PC `p` appears on `if_*` one cycle after `imem_addr == p`.
- First valid slot: second rising edge after reset deasserts (IDLE costs one cycle).
- Taken-branch penalty: `br_taken` at edge N sets the PC to the target and clears `if_valid`. The target instruction is valid after edge N+1.
- Throughput: 1 instruction/cycle with `id_ready` held high.
- `halted` rises at the edge that enters HALT.
- Asserting `reset` in any state overrides everything at the next edge.

## Structure
- Shared package `cpu_pkg`:
  - `INSTR_W = 32`
  - `PC_STEP = 64'd4`
  - `fetch_state_t` enum {IDLE, RUN, HALT}
  - type `addr_t = logic [63:0]`
- Sub-module `pc_target`: combinational `br_pc + (br_offset << 2)` / register mux, plus the misalignment detect. It is instantiated once. The state register, PC register and IF/ID slot stay in `pc_fetch`.

## Test plan
- Reset with `RESET_PC = 0x100` and `id_ready = 1` → `imem_addr = 0x100`, `if_valid = 0` for 1 cycle. Then `if_pc = 0x100`, 0x104, 0x108 on successive cycles.
- Stall: hold `id_ready = 0` for 3 cycles while the slot holds `if_pc = 0x104` → `if_pc`/`if_instr` are unchanged and `imem_addr = 0x108` throughout. When released, `0x108` follows next.
- Backward branch: `br_taken = 1`, `br_pc = 0x200`, `br_offset = 64'hFFFF_FFFF_FFFF_FFFE` → next `imem_addr = 0x1F8`, `if_valid = 0` for one cycle, then `if_pc = 0x1F8`.
- Branch during stall, with `br_reg = 1` and `br_reg_target = 0x3002` → the slot is flushed, PC = `0x3000`, `misalign_err = 1` and stays 1 until reset.
- Wrap: PC = `0xFFFF_FFFF_FFFF_FFFC`, advance → PC = `0x0`. A branch with `br_pc = 0xFFFF_FFFF_FFFF_FFF0` and `br_offset = 8` → target = `0x10`.
- Halt: `halt_req` with a valid unaccepted slot → `halted = 1`, the slot is kept until `id_ready`, then `if_valid = 0` permanently. `reset` returns to IDLE with `halted = 0`.
